fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Program-counter sequencer that drives the instruction ROM address (prog_ctr) for the 9-bit core.
- Owns the run/halt lifecycle: waits for start, steps the PC each cycle, applies branch redirects and stalls from decode/execute, and raises done on halt.
- Sits between the top-level testbench/start logic and the instruction ROM; the decoder feeds back branch and halt controls.

Parameters:
- D, 12, PC/ROM address width; the ROM holds 2**D words.
- START_ADDR, 0, PC value loaded on each start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin execution; sampled in IDLE and HALT only.
- stall  input  1  hold the PC this cycle.
- branch_en  input  1  take a branch at the current PC.
- branch_rel  input  1  1 = PC-relative branch, 0 = absolute branch.
- target  input  D  absolute address, or a signed two's-complement offset when branch_rel=1.
- halt_req  input  1  current instruction is the halt.
- prog_ctr  output  D  instruction ROM address (registered).
- fetch_valid  output  1  prog_ctr holds a live fetch address (RUN state).
- done  output  1  program finished (HALT state).

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high; all state is updated on the rising edge of clk.
- All outputs are registered.
- Reset values: state=IDLE, prog_ctr=0, fetch_valid=0, done=0. Reset overrides every other input, including in the middle of a run.
- States:
  - IDLE: PC holds. If start=1, go to RUN next cycle with prog_ctr=START_ADDR and fetch_valid=1.
  - RUN: per-cycle priority is stall > halt_req > branch_en > sequential.
    - stall=1: prog_ctr holds, state holds; halt_req and branch_en are ignored that cycle.
    - halt_req=1: go to HALT. prog_ctr holds (points at the halt instruction). fetch_valid=0 and done=1 from the next cycle.
    - branch_en=1 and branch_rel=0: prog_ctr <= target.
    - branch_en=1 and branch_rel=1: prog_ctr <= prog_ctr + sign-extended target, truncated to D bits (mod 2**D).
    - Otherwise: prog_ctr <= prog_ctr + 1, mod 2**D. 2**D-1 wraps to 0 with no error.
    - start is ignored in RUN.
  - HALT: done=1 and prog_ctr hold. If start=1, go to RUN next cycle with prog_ctr=START_ADDR, done=0, fetch_valid=1.
- Latency: a redirect or increment decided in cycle N appears on prog_ctr in cycle N+1. The ROM is combinational, so the instruction is available in the same cycle.
- Same-cycle conflicts: halt_req together with branch_en means halt wins. start together with reset means reset wins.
- Branch controls asserted outside RUN are ignored.

Optional Feature:
- Macro: FETCH_CTRL_INSTR_CNT_EN.
- When defined:
  - Adds output instr_cnt (16 bits).
  - Cleared by reset and on every start that enters RUN.
  - Increments by 1 on each RUN cycle with stall=0, including the halting cycle.
  - Saturates at 16'hFFFF.
  - Holds in IDLE and HALT.
- When undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- Sequential run: reset, then pulse start, then 5 idle cycles -> prog_ctr 0,1,2,3,4,5 with fetch_valid=1 and done=0.
- Absolute branch, then relative branch:
  - At PC=3, branch_en=1, branch_rel=0, target=12'h020 -> next PC=0x020.
  - Then branch_rel=1, target=12'hFFE (-2) -> PC=0x01E.
  - Then sequential -> 0x01F.
- Stall and conflicts:
  - Hold stall=1 for 3 cycles at PC=7 with halt_req=1 and branch_en=1 asserted -> PC stays 7, no halt.
  - Release stall with halt_req=1 and branch_en=1 -> HALT, PC=7, done=1 next cycle.
- Wrap: branch to 12'hFFF, then 1 sequential cycle -> PC=0x000; fetch_valid stays 1.
- Restart and reset:
  - From HALT, pulse start -> PC=START_ADDR, done=0.
  - Assert reset in RUN at PC=9 -> next cycle IDLE, PC=0, fetch_valid=0, done=0.
- With FETCH_CTRL_INSTR_CNT_EN defined: start, 4 run cycles, 2 stalled cycles, then halt -> instr_cnt=5 (4 run cycles plus the halting cycle), held in HALT; cleared to 0 on the next start.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : PC sequencer for the 9-bit core. Handles start/run/halt, branch
//            redirects and stalls. Optional macro FETCH_CTRL_INSTR_CNT_EN adds
//            a saturating 16-bit retired-instruction counter (instr_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int             D          = 12,
    parameter logic [D-1:0]   START_ADDR = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         branch_en,
    input  logic         branch_rel,
    input  logic [D-1:0] target,
    input  logic         halt_req,
    output logic [D-1:0] prog_ctr,
    output logic         fetch_valid,
    output logic         done
`ifdef FETCH_CTRL_INSTR_CNT_EN
    ,
    output logic [15:0]  instr_cnt
`endif
);

    localparam logic [D-1:0] c_pc_one = D'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [D-1:0]   w_pc_nx;
    logic           w_fv_nx;
    logic           w_done_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            prog_ctr    <= '0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            prog_ctr    <= w_pc_nx;
            fetch_valid <= w_fv_nx;
            done        <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = prog_ctr;
        w_fv_nx    = fetch_valid;
        w_done_nx  = done;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_state_nx = S_RUN;
                    w_pc_nx    = START_ADDR;
                    w_fv_nx    = 1'b1;
                    w_done_nx  = 1'b0;
                end
            end
            S_RUN: begin
                // Stall freezes everything, so halt/branch must wait for release.
                if (stall) begin
                    w_pc_nx = prog_ctr;
                end else if (halt_req) begin
                    w_state_nx = S_HALT;
                    w_fv_nx    = 1'b0;
                    w_done_nx  = 1'b1;
                end else if (branch_en) begin
                    w_pc_nx = branch_rel ? (prog_ctr + target) : target;
                end else begin
                    w_pc_nx = prog_ctr + c_pc_one;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_fv_nx    = 1'b0;
                w_done_nx  = 1'b0;
            end
        endcase
    end

`ifdef FETCH_CTRL_INSTR_CNT_EN
    logic w_enter_run;
    logic w_count;

    assign w_enter_run = (r_state != S_RUN) && start;
    assign w_count     = (r_state == S_RUN) && !stall && (instr_cnt != 16'hFFFF);

    always_ff @(posedge clk) begin
        if (reset || w_enter_run) begin
            instr_cnt <= 16'd0;
        end else if (w_count) begin
            instr_cnt <= instr_cnt + 16'd1;
        end
    end
`else
    // Instruction counter not built; no extra state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl; each stimulus row carries the
//            expected registered outputs for the following cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_en;
    logic        branch_rel;
    logic [11:0] target;
    logic        halt_req;
    logic [11:0] prog_ctr;
    logic        fetch_valid;
    logic        done;
`ifdef FETCH_CTRL_INSTR_CNT_EN
    logic [15:0] instr_cnt;
`endif

    fetch_ctrl #(.D(12), .START_ADDR(12'h000)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .branch_en   (branch_en),
        .branch_rel  (branch_rel),
        .target      (target),
        .halt_req    (halt_req),
        .prog_ctr    (prog_ctr),
        .fetch_valid (fetch_valid),
        .done        (done)
`ifdef FETCH_CTRL_INSTR_CNT_EN
        ,
        .instr_cnt   (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {reset, start, stall, branch_en, branch_rel, halt_req}; exp = {fetch_valid, done}
    typedef struct packed {
        logic [5:0]  ctl;
        logic [11:0] tg;
        logic [11:0] epc;
        logic [1:0]  exp;
        logic [15:0] ecnt;
    } stim_t;

    typedef struct packed {
        logic [11:0] pc;
        logic [1:0]  fd;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic apply(input stim_t s);
        {reset, start, stall, branch_en, branch_rel, halt_req} = s.ctl;
        target = s.tg;
        sb.push_back('{pc: s.epc, fd: s.exp, cnt: s.ecnt});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t t[$];
        exp_t  e;
        t = '{
            '{6'b110000, 12'h000, 12'h000, 2'b00, 16'd0},
            '{6'b100000, 12'h000, 12'h000, 2'b00, 16'd0},
            '{6'b000101, 12'h055, 12'h000, 2'b00, 16'd0},
            '{6'b000000, 12'h000, 12'h000, 2'b00, 16'd0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({prog_ctr, fetch_valid, done} !== {e.pc, e.fd}) begin
                n_err++;
                $display("FAIL reset[%0d]: got pc=%h fv=%b done=%b, expected pc=%h fv=%b done=%b",
                         i, prog_ctr, fetch_valid, done, e.pc, e.fd[1], e.fd[0]);
            end
        end
    endtask

    task automatic test_sequential();
        stim_t t[$];
        exp_t  e;
        t = '{
            '{6'b010000, 12'h000, 12'h000, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h001, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h002, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h003, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h004, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h005, 2'b10, 16'd0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({prog_ctr, fetch_valid, done} !== {e.pc, e.fd}) begin
                n_err++;
                $display("FAIL sequential[%0d]: got pc=%h fv=%b done=%b, expected pc=%h fv=%b done=%b",
                         i, prog_ctr, fetch_valid, done, e.pc, e.fd[1], e.fd[0]);
            end
        end
    endtask

    task automatic test_branch();
        stim_t t[$];
        exp_t  e;
        t = '{
            '{6'b100000, 12'h000, 12'h000, 2'b00, 16'd0},
            '{6'b010000, 12'h000, 12'h000, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h001, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h002, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h003, 2'b10, 16'd0},
            '{6'b000100, 12'h020, 12'h020, 2'b10, 16'd0},
            '{6'b000110, 12'hFFE, 12'h01E, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h01F, 2'b10, 16'd0},
            '{6'b000110, 12'h005, 12'h024, 2'b10, 16'd0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({prog_ctr, fetch_valid, done} !== {e.pc, e.fd}) begin
                n_err++;
                $display("FAIL branch[%0d]: got pc=%h fv=%b done=%b, expected pc=%h fv=%b done=%b",
                         i, prog_ctr, fetch_valid, done, e.pc, e.fd[1], e.fd[0]);
            end
        end
    endtask

    task automatic test_stall_halt();
        stim_t t[$];
        exp_t  e;
        t = '{
            '{6'b000100, 12'h007, 12'h007, 2'b10, 16'd0},
            '{6'b001101, 12'h100, 12'h007, 2'b10, 16'd0},
            '{6'b001101, 12'h100, 12'h007, 2'b10, 16'd0},
            '{6'b001101, 12'h100, 12'h007, 2'b10, 16'd0},
            '{6'b000101, 12'h100, 12'h007, 2'b01, 16'd0},
            '{6'b000110, 12'h100, 12'h007, 2'b01, 16'd0},
            '{6'b000000, 12'h000, 12'h007, 2'b01, 16'd0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({prog_ctr, fetch_valid, done} !== {e.pc, e.fd}) begin
                n_err++;
                $display("FAIL stall_halt[%0d]: got pc=%h fv=%b done=%b, expected pc=%h fv=%b done=%b",
                         i, prog_ctr, fetch_valid, done, e.pc, e.fd[1], e.fd[0]);
            end
        end
    endtask

    task automatic test_restart_wrap();
        stim_t t[$];
        exp_t  e;
        t = '{
            '{6'b010000, 12'h000, 12'h000, 2'b10, 16'd0},
            '{6'b010000, 12'h000, 12'h001, 2'b10, 16'd0},
            '{6'b000100, 12'hFFF, 12'hFFF, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h000, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h001, 2'b10, 16'd0},
            '{6'b000110, 12'hFFD, 12'hFFE, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'hFFF, 2'b10, 16'd0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({prog_ctr, fetch_valid, done} !== {e.pc, e.fd}) begin
                n_err++;
                $display("FAIL restart_wrap[%0d]: got pc=%h fv=%b done=%b, expected pc=%h fv=%b done=%b",
                         i, prog_ctr, fetch_valid, done, e.pc, e.fd[1], e.fd[0]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        stim_t t[$];
        exp_t  e;
        t = '{
            '{6'b000100, 12'h009, 12'h009, 2'b10, 16'd0},
            '{6'b110100, 12'h033, 12'h000, 2'b00, 16'd0},
            '{6'b000000, 12'h000, 12'h000, 2'b00, 16'd0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({prog_ctr, fetch_valid, done} !== {e.pc, e.fd}) begin
                n_err++;
                $display("FAIL reset_midrun[%0d]: got pc=%h fv=%b done=%b, expected pc=%h fv=%b done=%b",
                         i, prog_ctr, fetch_valid, done, e.pc, e.fd[1], e.fd[0]);
            end
        end
    endtask

`ifdef FETCH_CTRL_INSTR_CNT_EN
    task automatic test_instr_cnt();
        stim_t t[$];
        exp_t  e;
        t = '{
            '{6'b010000, 12'h000, 12'h000, 2'b10, 16'd0},
            '{6'b000000, 12'h000, 12'h001, 2'b10, 16'd1},
            '{6'b000000, 12'h000, 12'h002, 2'b10, 16'd2},
            '{6'b000000, 12'h000, 12'h003, 2'b10, 16'd3},
            '{6'b000000, 12'h000, 12'h004, 2'b10, 16'd4},
            '{6'b001000, 12'h000, 12'h004, 2'b10, 16'd4},
            '{6'b001000, 12'h000, 12'h004, 2'b10, 16'd4},
            '{6'b000001, 12'h000, 12'h004, 2'b01, 16'd5},
            '{6'b000000, 12'h000, 12'h004, 2'b01, 16'd5},
            '{6'b010000, 12'h000, 12'h000, 2'b10, 16'd0}
        };
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({prog_ctr, fetch_valid, done, instr_cnt} !== {e.pc, e.fd, e.cnt}) begin
                n_err++;
                $display("FAIL instr_cnt[%0d]: got pc=%h fv=%b done=%b cnt=%0d, expected pc=%h fv=%b done=%b cnt=%0d",
                         i, prog_ctr, fetch_valid, done, instr_cnt, e.pc, e.fd[1], e.fd[0], e.cnt);
            end
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stall      = 1'b0;
        branch_en  = 1'b0;
        branch_rel = 1'b0;
        target     = 12'h000;
        halt_req   = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall_halt();
        test_restart_wrap();
        test_reset_midrun();
`ifdef FETCH_CTRL_INSTR_CNT_EN
        test_instr_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
